// File: rtl/zed_led_pkg.sv
// Shared types for the ZedBoard LED driver: per-LED mode encoding and committed config record.
// With ZED_LED_BREATHE_EN defined, mode 3 is BREATHE; otherwise it is BLINK.
package zed_led_pkg;

  localparam int MODE_W      = 2;
  localparam int LEVEL_W_MAX = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_PWM     = 2'd2,
`ifdef ZED_LED_BREATHE_EN
    MODE_BREATHE = 2'd3
`else
    MODE_BLINK   = 2'd3
`endif
  } led_mode_t;

  // Level is stored at the widest supported PWM width and zero-extended on capture.
  typedef struct packed {
    led_mode_t              mode;
    logic [LEVEL_W_MAX-1:0] level;
  } led_cfg_t;

  function automatic logic duty_on(input logic [LEVEL_W_MAX-1:0] level,
                                   input logic [LEVEL_W_MAX-1:0] cnt);
    return level > cnt;
  endfunction

endpackage

// File: rtl/zed_led_timebase.sv
// Shared timing for all LEDs: prescaler tick, PWM counter, period boundary and blink phase.
module zed_led_timebase #(
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int BLINK_WIDTH    = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic [BLINK_WIDTH-1:0]    i_blink_half,
  output logic [PWM_WIDTH-1:0]      o_pwm_cnt,
  output logic                      o_boundary,
  output logic                      o_phase
);

  logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
  logic [PRESCALE_WIDTH-1:0] r_pre_lim;
  logic [PWM_WIDTH-1:0]      r_pwm_cnt;
  logic [BLINK_WIDTH-1:0]    r_blink_cnt;
  logic                      r_phase;
  logic [PRESCALE_WIDTH-1:0] w_pre_limit;
  logic                      w_tick;
  logic                      w_boundary;

  // The count-0 clock is the reload point: it sees the live input and latches it for the rest of the count.
  assign w_pre_limit = (r_pre_cnt == '0) ? i_prescale : r_pre_lim;
  assign w_tick      = (r_pre_cnt == w_pre_limit);
  assign w_boundary  = w_tick & (r_pwm_cnt == '1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pre_cnt   <= '0;
      r_pre_lim   <= '0;
      r_pwm_cnt   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      if (r_pre_cnt == '0)
        r_pre_lim <= i_prescale;
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick)
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_boundary) begin
        if (r_blink_cnt == i_blink_half) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign o_pwm_cnt  = r_pwm_cnt;
  assign o_boundary = w_boundary;
  assign o_phase    = r_phase;

endmodule

// File: rtl/zed_led_driver.sv
// LED driver top: config write FSM with a shadow register that commits at PWM period boundaries.
// Optional ZED_LED_BREATHE_EN turns mode 3 into a per-LED triangle brightness ramp.
module zed_led_driver
  import zed_led_pkg::*;
#(
  parameter int LED_COUNT      = 8,
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int BLINK_WIDTH    = 16
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [PRESCALE_WIDTH-1:0]    i_prescale,
  input  logic [BLINK_WIDTH-1:0]       i_blink_half,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic [$clog2(LED_COUNT)-1:0] i_cfg_index,
  input  logic [1:0]                   i_cfg_mode,
  input  logic [PWM_WIDTH-1:0]         i_cfg_level,
  output logic [LED_COUNT-1:0]         o_led,
  output logic                         o_period_start
);

  localparam int IDX_W = $clog2(LED_COUNT);

  typedef enum logic {ST_IDLE, ST_PENDING} cfg_state_t;

  cfg_state_t             r_state;
  cfg_state_t             w_state_next;
  logic [IDX_W-1:0]       r_sh_index;
  led_cfg_t               r_sh_cfg;
  logic [LED_COUNT-1:0]   r_led;
  logic                   r_period_start;
  logic [LED_COUNT-1:0]   w_led_next;
  logic [PWM_WIDTH-1:0]   w_pwm_cnt;
  logic [LEVEL_W_MAX-1:0] w_cnt_ext;
  logic                   w_boundary;
  logic                   w_phase;
  logic                   w_accept;
  logic                   w_idx_ok;
  logic                   w_capture;
  logic                   w_commit;

  zed_led_timebase #(
    .PWM_WIDTH      (PWM_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BLINK_WIDTH    (BLINK_WIDTH)
  ) u_timebase (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_prescale   (i_prescale),
    .i_blink_half (i_blink_half),
    .o_pwm_cnt    (w_pwm_cnt),
    .o_boundary   (w_boundary),
    .o_phase      (w_phase)
  );

  assign w_cnt_ext   = LEVEL_W_MAX'(w_pwm_cnt);
  assign o_cfg_ready = (r_state == ST_IDLE) & ~i_reset;
  assign w_accept    = i_cfg_valid & o_cfg_ready;
  assign w_idx_ok    = int'(i_cfg_index) < LED_COUNT;
  assign w_commit    = (r_state == ST_PENDING) & w_boundary;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Out-of-range indices are handshaken but never reach the shadow.
        if (w_accept && w_idx_ok) begin
          w_capture    = 1'b1;
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_boundary)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_sh_index <= '0;
      r_sh_cfg   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_sh_index     <= i_cfg_index;
        r_sh_cfg.mode  <= led_mode_t'(i_cfg_mode);
        r_sh_cfg.level <= LEVEL_W_MAX'(i_cfg_level);
      end
    end
  end

  for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_led
    led_cfg_t r_cfg;
    logic     w_sel;
    logic     w_on;

    assign w_sel = w_commit & (r_sh_index == IDX_W'(gi));

    always_ff @(posedge i_clock) begin
      if (i_reset)
        r_cfg <= '0;
      else if (w_sel)
        r_cfg <= r_sh_cfg;
    end

`ifdef ZED_LED_BREATHE_EN
    logic [PWM_WIDTH-1:0] r_eff;
    logic                 r_up;
    logic [PWM_WIDTH-1:0] w_lvl;

    assign w_lvl = r_cfg.level[PWM_WIDTH-1:0];

    // Triangle ramp 0..level..0, one step per period; the turning points are each visited once.
    always_ff @(posedge i_clock) begin
      if (i_reset || w_sel) begin
        r_eff <= '0;
        r_up  <= 1'b1;
      end else if (w_boundary && r_cfg.mode == MODE_BREATHE) begin
        if (r_up) begin
          if (r_eff >= w_lvl) begin
            r_up <= 1'b0;
            if (r_eff != '0)
              r_eff <= r_eff - 1'b1;
          end else begin
            r_eff <= r_eff + 1'b1;
          end
        end else if (r_eff == '0) begin
          r_up <= 1'b1;
          if (w_lvl != '0)
            r_eff <= r_eff + 1'b1;
        end else begin
          r_eff <= r_eff - 1'b1;
        end
      end
    end
`endif

    always_comb begin
      w_on = 1'b0;
      case (r_cfg.mode)
        MODE_OFF:     w_on = 1'b0;
        MODE_ON:      w_on = 1'b1;
        MODE_PWM:     w_on = duty_on(r_cfg.level, w_cnt_ext);
`ifdef ZED_LED_BREATHE_EN
        MODE_BREATHE: w_on = duty_on(LEVEL_W_MAX'(r_eff), w_cnt_ext);
`else
        MODE_BLINK:   w_on = w_phase & duty_on(r_cfg.level, w_cnt_ext);
`endif
        default:      w_on = 1'b0;
      endcase
    end

    assign w_led_next[gi] = w_on;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_led          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_led          <= w_led_next;
      r_period_start <= w_boundary;
    end
  end

  assign o_led          = r_led;
  assign o_period_start = r_period_start;

endmodule

// File: tb/tb_zed_led_driver.sv
// Self-checking bench for zed_led_driver (default build, mode 3 = BLINK).
// Six LEDs so that an index of 6 or 7 is representable and exercises the out-of-range discard.
module tb_zed_led_driver;

  localparam int LEDS = 6;
  localparam int PW   = 8;
  localparam int PSW  = 16;
  localparam int BW   = 16;
  localparam int IW   = $clog2(LEDS);

  logic            clk = 1'b0;
  logic            rst;
  logic [PSW-1:0]  prescale;
  logic [BW-1:0]   blink_half;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [IW-1:0]   cfg_index;
  logic [1:0]      cfg_mode;
  logic [PW-1:0]   cfg_level;
  logic [LEDS-1:0] led;
  logic            period_start;

  always #5 clk = ~clk;

  zed_led_driver #(
    .LED_COUNT      (LEDS),
    .PWM_WIDTH      (PW),
    .PRESCALE_WIDTH (PSW),
    .BLINK_WIDTH    (BW)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_prescale     (prescale),
    .i_blink_half   (blink_half),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_index    (cfg_index),
    .i_cfg_mode     (cfg_mode),
    .i_cfg_level    (cfg_level),
    .o_led          (led),
    .o_period_start (period_start)
  );

  int n_vec = 0;
  int n_bad = 0;
  int m_mode [LEDS];
  int m_lvl  [LEDS];
  int exp_q  [$];

  typedef struct {
    int idx;
    int mode;
    int level;
    int pre;
    int exp_high;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic note_timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got no event within the cycle budget, required one", name);
  endtask

  function automatic logic exp_bit(input int mode, input int lvl, input int pwm);
    case (mode)
      1:       return 1'b1;
      2:       return lvl > pwm;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LEDS-1:0] exp_vec(input int pwm);
    logic [LEDS-1:0] v;
    for (int i = 0; i < LEDS; i++) v[i] = exp_bit(m_mode[i], m_lvl[i], pwm);
    return v;
  endfunction

  // Returns at the negedge of the cycle after the accept, with valid dropped.
  task automatic cfg_write(input int idx, input int mode, input int lvl);
    bit done = 0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_index = IW'(idx);
      cfg_mode  = 2'(mode);
      cfg_level = PW'(lvl);
      @(negedge clk);
      done = cfg_ready;
    end
    if (!done) note_timeout("cfg_write");
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      ok = cfg_ready;
    end
    if (!ok) note_timeout("wait_ready");
  endtask

  task automatic wait_pstart(output bit ok);
    ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      ok = period_start;
    end
    if (!ok) note_timeout("wait_period_start");
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int high, bad, bad_r, bad_p, n_edges, rdy_a, rdy_b;
    int d_exp [8] = '{0, 255, 255, 0, 0, 255, 255, 0};

    vecs[0] = '{idx: 0, mode: 2, level: 64,  pre: 0, exp_high: 64};
    vecs[1] = '{idx: 1, mode: 1, level: 0,   pre: 0, exp_high: 256};
    vecs[2] = '{idx: 2, mode: 2, level: 255, pre: 0, exp_high: 255};
    vecs[3] = '{idx: 3, mode: 2, level: 0,   pre: 0, exp_high: 0};
    vecs[4] = '{idx: 3, mode: 2, level: 1,   pre: 1, exp_high: 2};
    vecs[5] = '{idx: 5, mode: 2, level: 128, pre: 2, exp_high: 384};
    vecs[6] = '{idx: 2, mode: 0, level: 200, pre: 0, exp_high: 0};
    vecs[7] = '{idx: 0, mode: 2, level: 200, pre: 0, exp_high: 200};

    for (int i = 0; i < LEDS; i++) begin
      m_mode[i] = 0;
      m_lvl[i]  = 0;
    end

    rst        = 1'b1;
    prescale   = '0;
    blink_half = BW'(1);
    cfg_valid  = 1'b0;
    cfg_index  = '0;
    cfg_mode   = '0;
    cfg_level  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_ready", int'(cfg_ready), 0);
    check("reset_pstart", int'(period_start), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", int'(cfg_ready), 1);

    // Table-driven steady-state patterns over one full PWM period after each commit
    foreach (vecs[v]) begin
      prescale = PSW'(vecs[v].pre);
      cfg_write(vecs[v].idx, vecs[v].mode, vecs[v].level);
      check($sformatf("v%0d_ready_pending", v), int'(cfg_ready), 0);
      exp_q.push_back(vecs[v].exp_high);
      m_mode[vecs[v].idx] = vecs[v].mode;
      m_lvl[vecs[v].idx]  = vecs[v].level;
      wait_ready(ok);
      check($sformatf("v%0d_pstart_at_commit", v), int'(period_start), 1);
      high = 0;
      bad  = 0;
      for (int j = 0; j < 256 * (vecs[v].pre + 1); j++) begin
        @(negedge clk);
        if (led[vecs[v].idx]) high++;
        if (led !== exp_vec(j / (vecs[v].pre + 1))) bad++;
      end
      check($sformatf("v%0d_high_clocks", v), high, exp_q.pop_front());
      check($sformatf("v%0d_pattern_errs", v), bad, 0);
    end

    // Mid-period rewrite of LED0 200 -> 64: old level holds until the boundary
    prescale = '0;
    wait_pstart(ok);
    bad = 0; bad_r = 0; bad_p = 0; rdy_a = -1; rdy_b = -1;
    for (int p = 1; p <= 600; p++) begin
      @(posedge clk); #1;
      cfg_valid = (p == 100);
      cfg_index = IW'(0);
      cfg_mode  = 2'd2;
      cfg_level = PW'(64);
      @(negedge clk);
      m_lvl[0] = ((p - 1) >= 256) ? 64 : 200;
      if (led !== exp_vec((p - 1) % 256)) bad++;
      if (int'(cfg_ready) != ((p >= 101 && p <= 255) ? 0 : 1)) bad_r++;
      if (int'(period_start) != ((p % 256 == 0) ? 1 : 0)) bad_p++;
      if (p == 101) rdy_a = int'(cfg_ready);
      if (p == 256) rdy_b = int'(cfg_ready);
    end
    cfg_valid = 1'b0;
    m_lvl[0]  = 64;
    check("mid_ready_after_accept", rdy_a, 0);
    check("mid_ready_after_boundary", rdy_b, 1);
    check("mid_led_errs", bad, 0);
    check("mid_ready_errs", bad_r, 0);
    check("mid_pstart_errs", bad_p, 0);

    // Out-of-range index 7: handshaken, no state change, LED1 stays on
    wait_pstart(ok);
    bad = 0; bad_r = 0; high = 0; rdy_a = -1;
    for (int p = 1; p <= 600; p++) begin
      @(posedge clk); #1;
      cfg_valid = (p == 50);
      cfg_index = IW'(7);
      cfg_mode  = 2'd1;
      cfg_level = PW'(255);
      @(negedge clk);
      if (led !== exp_vec((p - 1) % 256)) bad++;
      if (cfg_ready !== 1'b1) bad_r++;
      if (led[1]) high++;
      if (p == 51) rdy_a = int'(cfg_ready);
    end
    cfg_valid = 1'b0;
    check("oor_ready_next_clock", rdy_a, 1);
    check("oor_ready_errs", bad_r, 0);
    check("oor_led_errs", bad, 0);
    check("oor_led1_on_clocks", high, 600);

    // Reset while PENDING drops the write; then BLINK from a known phase
    wait_pstart(ok);
    cfg_write(0, 1, 0);
    check("rst_pending_ready", int'(cfg_ready), 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (cfg_ready !== 1'b0) bad++;
      if (c > 0 && (led !== '0 || period_start !== 1'b0)) bad++;
    end
    check("mid_reset_outputs_errs", bad, 0);
    for (int i = 0; i < LEDS; i++) begin
      m_mode[i] = 0;
      m_lvl[i]  = 0;
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    cfg_valid = 1'b1;
    cfg_index = IW'(4);
    cfg_mode  = 2'd3;
    cfg_level = PW'(255);
    @(negedge clk);
    check("rst_ready_first_clock", int'(cfg_ready), 1);
    n_edges = 0;
    bad     = 0;
    ok      = 0;
    while (!ok && n_edges < 1000) begin
      @(posedge clk);
      n_edges++;
      #1 cfg_valid = 1'b0;
      @(negedge clk);
      ok = period_start;
      if (led !== '0) bad++;
    end
    check("rst_first_pstart_clocks", n_edges, 256);
    check("rst_no_commit_led_errs", bad, 0);
    for (int m = 0; m < 8; m++) begin
      high = 0;
      bad  = 0;
      for (int j = 0; j < 256; j++) begin
        @(negedge clk);
        if (led[4]) high++;
        if ((led & ~LEDS'(6'b010000)) !== '0) bad++;
      end
      check($sformatf("blink_period%0d_high", m), high, d_exp[m]);
      check($sformatf("blink_period%0d_other_errs", m), bad, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
